// File: rtl/cache_mem_arbiter.sv
// Shares the main-memory line port between the I-cache and the D-cache.
// Optional ARB_ROUND_ROBIN_EN: alternate ties between the caches instead of D-first.
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_mem_read,
    input  logic              ic_mem_write,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    input  logic [DATA_W-1:0] ic_mem_wdata,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   req_i, req_d;
    logic   tie_to_d;

    assign req_i = ic_mem_read | ic_mem_write;
    assign req_d = dc_mem_read | dc_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // a tie goes to whichever cache did not own the port last
    assign tie_to_d = ~last_grant_q;
`else
    // fixed priority: the D-cache wins every tie
    assign tie_to_d = 1'b1;
`endif

    // state and last-owner registers; reset leaves D as last owner
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // next-state: grant from IDLE, hold the grant until memory completes
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = tie_to_d ? GNT_D : GNT_I;
                end else if (req_i) begin
                    state_d = GNT_I;
                end else if (req_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // memory-side mux of the owner's request and ready steering back to it
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ic_mem_ready = 1'b0;
        dc_mem_ready = 1'b0;
        unique case (state_q)
            GNT_I: begin
                mem_read     = ic_mem_read;
                mem_write    = ic_mem_write;
                mem_addr     = ic_mem_addr;
                mem_wdata    = ic_mem_wdata;
                ic_mem_ready = mem_ready;
            end
            GNT_D: begin
                mem_read     = dc_mem_read;
                mem_write    = dc_mem_write;
                mem_addr     = dc_mem_addr;
                mem_wdata    = dc_mem_wdata;
                dc_mem_ready = mem_ready;
            end
            default: begin
            end
        endcase
    end

    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;
    assign grant        = {state_q == GNT_D, state_q == GNT_I};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed vector bench for cache_mem_arbiter.
// Tie expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_cache_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [AW-1:0] IA = 28'h0000010;
    localparam logic [AW-1:0] DA = 28'h0000020;
    localparam logic [DW-1:0] IWD = 128'hCAFEF00D_0BADBEEF_11112222_33334444;
    localparam logic [DW-1:0] DWD = 128'h12345678_9ABCDEF0_12345678_9ABCDEF0;
    localparam logic [DW-1:0] RD = {16{8'hA5}};
    localparam logic [1:0] TA = RR ? 2'b01 : 2'b10;
    localparam logic [1:0] TB = RR ? 2'b10 : 2'b01;

    logic clk = 1'b0;
    logic proc_reset;
    logic ic_mem_read, ic_mem_write;
    logic [AW-1:0] ic_mem_addr;
    logic [DW-1:0] ic_mem_wdata, ic_mem_rdata;
    logic ic_mem_ready;
    logic dc_mem_read, dc_mem_write;
    logic [AW-1:0] dc_mem_addr;
    logic [DW-1:0] dc_mem_wdata, dc_mem_rdata;
    logic dc_mem_ready;
    logic mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic mem_ready;
    logic [1:0] grant;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .ic_mem_read(ic_mem_read), .ic_mem_write(ic_mem_write),
        .ic_mem_addr(ic_mem_addr), .ic_mem_wdata(ic_mem_wdata),
        .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
        .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
        .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
        .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant)
    );

    typedef struct {
        logic rst, ir, iw, dr, dw, mr;
        logic [1:0] eg;
        logic erd, ewr;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail = 0;
    int cur = -1;

    function automatic vec_t mk(logic rst, logic ir, logic iw, logic dr,
                                logic dw, logic mr, logic [1:0] eg,
                                logic erd, logic ewr);
        vec_t v;
        v.rst = rst; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.mr = mr;
        v.eg = eg; v.erd = erd; v.ewr = ewr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h want %h", nm, cur, act, exp);
        end
    endtask

    task automatic check_all(input logic [1:0] eg, input logic erd,
                             input logic ewr, input logic mr);
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        ea  = (eg == 2'b01) ? IA  : (eg == 2'b10) ? DA  : '0;
        ewd = (eg == 2'b01) ? IWD : (eg == 2'b10) ? DWD : '0;
        chk("grant", DW'(grant), DW'(eg));
        chk("mem_read", DW'(mem_read), DW'(erd));
        chk("mem_write", DW'(mem_write), DW'(ewr));
        chk("mem_addr", DW'(mem_addr), DW'(ea));
        chk("mem_wdata", mem_wdata, ewd);
        chk("ic_ready", DW'(ic_mem_ready), DW'((eg == 2'b01) && mr));
        chk("dc_ready", DW'(dc_mem_ready), DW'((eg == 2'b10) && mr));
        chk("ic_rdata", ic_mem_rdata, RD);
        chk("dc_rdata", dc_mem_rdata, RD);
    endtask

    initial begin
        // single I read, ready after 3 cycles
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'b01, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'b01, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        // single D write
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2'b10, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        // reset, then tie; loser keeps requesting
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, TA, 1, 0));
        vecs.push_back(mk(0, !RR, 0, RR, 0, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, !RR, 0, RR, 0, 1, TB, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        // back-to-back ties, both requesting continuously
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2'b00, 0, 0));
            vecs.push_back(mk(0, 1, 0, 1, 0, 1,
                              RR ? ((k % 2 == 1) ? 2'b10 : 2'b01) : 2'b10,
                              1, 0));
        end
        // spurious mem_ready in IDLE
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        // I write, owner drops, D requests meanwhile
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'b01, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'b01, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 2'b01, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
        // D read, reset during GNT_D, then tie
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'b10, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 2'b10, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, TA, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));

        proc_reset   = 1'b1;
        ic_mem_read  = 1'b0;
        ic_mem_write = 1'b0;
        ic_mem_addr  = IA;
        ic_mem_wdata = IWD;
        dc_mem_read  = 1'b0;
        dc_mem_write = 1'b0;
        dc_mem_addr  = DA;
        dc_mem_wdata = DWD;
        mem_rdata    = RD;
        mem_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        #1;
        check_all(2'b00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur          = i;
            proc_reset   = vecs[i].rst;
            ic_mem_read  = vecs[i].ir;
            ic_mem_write = vecs[i].iw;
            dc_mem_read  = vecs[i].dr;
            dc_mem_write = vecs[i].dw;
            mem_ready    = vecs[i].mr;
            #2;
            check_all(vecs[i].eg, vecs[i].erd, vecs[i].ewr, vecs[i].mr);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
